led_pattern_ctrl: RTL
=====================

# led_pattern_ctrl

Run/mode/speed controller for the 8-bit board LED bar. It takes three raw push-buttons, debounces them, and sequences one of four LED patterns at a selectable step rate. It sits between the board buttons and the `led` pins as the top-level light controller for the flowing-light demos.

## Interface
- `TICK_DIV`, default 100000000: clock cycles per pattern step at speed 0. Must be ≥ 8 and < 2^32.
- `DEBOUNCE_CYC`, default 1000000: consecutive stable cycles required to accept a button level change. Must be ≥ 1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `btn_start`  in  1  raw, async, active-high: start / pause / resume.
- `btn_mode`  in  1  raw, async, active-high: advance pattern mode.
- `btn_speed`  in  1  raw, async, active-high: advance speed.
- `led`  out  8  LED drive, registered.
- `mode`  out  2  current mode, registered.
- `speed`  out  2  current speed, registered.
- `running`  out  1  high only in state RUN, registered.

## Operation
- **Button path**, per button:
  - 2-FF synchronizer.
  - Debouncer: the debounced level takes the synced value once synced ≠ level for DEBOUNCE_CYC consecutive cycles. Any mismatch break restarts the count.
  - Rising-edge detect on the debounced level gives a 1-cycle pulse: `p_start`, `p_mode`, `p_speed`.
- **Mode register**: `p_mode` advances 0→1→2→3→0.
- **Speed register**: `p_speed` advances 0→1→2→3→0.
- **Step period**: `TICK_DIV >> speed`, i.e. TICK_DIV, /2, /4, /8. Use a 32-bit counter `cnt` that counts 0..period−1. The step tick fires when `cnt == period−1`, and `cnt` then returns to 0.
- **Seeds** (mode uses new value when changing same cycle):
  - mode 0: 8'h01
  - mode 1: 8'h80
  - mode 2: 8'h01, dir=left
  - mode 3: 8'h0F
- **Step actions**:
  - mode 0: rotate left, `{led[6:0],led[7]}`.
  - mode 1: rotate right, `{led[0],led[7:1]}`.
  - mode 2: ping-pong single bit. If dir=left and led==8'h80, set dir=right and shift right. If dir=right and led==8'h01, set dir=left and shift left. Otherwise shift in dir.
  - mode 3: `led <= ~led`, alternating 0F/F0.
- **FSM** states IDLE, RUN, PAUSE:
  - IDLE: led=0, cnt=0. On `p_start`: go to RUN, load seed, cnt=0.
  - RUN: cnt counts and steps apply on tick. On `p_start`: go to PAUSE.
  - PAUSE: led and cnt frozen. On `p_start`: go to RUN, continuing from the frozen cnt.
  - There is no return to IDLE except via reset.
- **Mode change** (`p_mode`):
  - In RUN or PAUSE: reload the new mode's seed, set dir=left, set cnt=0, and stay in the current state.
  - In IDLE: update the register only.
- **Speed change** (`p_speed`) in any state: set cnt=0. The new period applies from the next count.
- **Simultaneous events**:
  - All pulses act in the same cycle.
  - A mode reload overrides a step tick in the same cycle.
  - A speed-induced cnt clear overrides the tick; no step occurs that cycle.
  - `p_start` together with `p_mode` from IDLE loads the new mode's seed.

## Timing
- **Reset values**: led=8'h00, mode=0, speed=0, running=0. State IDLE, cnt=0, dir=left, debounced levels=0, synchronizers=0.
- **Reset mid-operation**: everything returns to these values immediately, asynchronously.
- **Button latency**: a button held from clock edge k produces its pulse, registered, at edge k+2+DEBOUNCE_CYC+1. The resulting state, led, mode or speed update is visible one edge later.
- Button release is debounced identically and produces no pulse.
- **First step**: after entering RUN from IDLE at edge e (led=seed), the first step is visible at edge e+period.
- A bounce shorter than DEBOUNCE_CYC cycles produces no pulse.

## Test plan
Use TICK_DIV=8, DEBOUNCE_CYC=4.
1. Reset, then press `btn_start` → running=1 and led=01. Steps every 8 cycles: 02, 04, …, 80, then 01.
2. Press mode three times from IDLE (mode=3), then start → led 0F, F0, 0F every 8 cycles. Press mode in RUN → mode=0, led=01, cnt restarts.
3. Mode 2 in RUN → led 01→02→…→80→40→…→01→02, with no repeated endpoint.
4. Speed pressed twice in RUN → speed=2, step every 2 cycles. Once more → every 1 cycle. Once more → wraps to speed 0, every 8 cycles.
5. Start in RUN → PAUSE, led frozen for 50 cycles. Start again → the next step arrives 8 cycles minus cnt-at-pause later.
6. Pulses of 1–3 cycles on `btn_start` → no state change. Assert `rst_n`=0 mid-RUN → led=00, mode=0, speed=0, running=0 immediately.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// Button-driven LED bar controller: debounces start/mode/speed buttons and
// sequences one of four 8-bit patterns at a selectable step rate.
module led_pattern_ctrl #(
  parameter int unsigned TICK_DIV     = 100000000,
  parameter int unsigned DEBOUNCE_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_mode,
  input  logic       btn_speed,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic [1:0] speed,
  output logic       running
);

  localparam int unsigned N_BTN = 3;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  logic [N_BTN-1:0] btn_raw_c;
  logic [N_BTN-1:0] sync1, sync2, level, level_q, pulse;
  logic [DB_W-1:0]  db_cnt [N_BTN];

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             dir_left;

  logic             p_start_c, p_mode_c, p_speed_c;
  logic [1:0]       mode_next_c, speed_next_c;
  logic [CNT_W-1:0] period_c;
  logic             tick_c;
  logic [8:0]       step_c;

  assign btn_raw_c = {btn_speed, btn_mode, btn_start};

  // Synchronize, debounce and edge-detect all three buttons in parallel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_q <= '0;
      pulse   <= '0;
      for (int i = 0; i < int'(N_BTN); i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= btn_raw_c;
      sync2   <= sync1;
      level_q <= level;
      pulse   <= level & ~level_q;
      for (int i = 0; i < int'(N_BTN); i++) begin
        if (sync2[i] != level[i]) begin
          if (db_cnt[i] == DB_W'(DEBOUNCE_CYC)) begin
            level[i]  <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign p_start_c = pulse[0];
  assign p_mode_c  = pulse[1];
  assign p_speed_c = pulse[2];

  function automatic logic [7:0] seed_of(input logic [1:0] m);
    case (m)
      2'd0:    return 8'h01;
      2'd1:    return 8'h80;
      2'd2:    return 8'h01;
      default: return 8'h0F;
    endcase
  endfunction

  // Next {dir_left, led} for one pattern step in the current mode.
  function automatic logic [8:0] step_of(input logic [1:0] m, input logic [7:0] l,
                                         input logic d);
    logic [8:0] r;
    r = {d, l};
    case (m)
      2'd0: r = {d, l[6:0], l[7]};
      2'd1: r = {d, l[0], l[7:1]};
      2'd2: begin
        if (d && l == 8'h80)       r = {1'b0, l >> 1};
        else if (!d && l == 8'h01) r = {1'b1, l << 1};
        else if (d)                r = {1'b1, l << 1};
        else                       r = {1'b0, l >> 1};
      end
      default: r = {d, ~l};
    endcase
    return r;
  endfunction

  always_comb begin
    mode_next_c  = mode + 2'(p_mode_c);
    speed_next_c = speed + 2'(p_speed_c);
    period_c     = CNT_W'(TICK_DIV) >> speed;
    tick_c       = (state == RUN) && (cnt == period_c - CNT_W'(1));
    step_c       = step_of(mode, led, dir_left);
  end

  // Run/pause sequencer; mode reload beats speed clear beats step tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      dir_left <= 1'b1;
      led      <= 8'h00;
      mode     <= 2'd0;
      speed    <= 2'd0;
      running  <= 1'b0;
    end else begin
      mode  <= mode_next_c;
      speed <= speed_next_c;
      case (state)
        IDLE: begin
          led      <= 8'h00;
          cnt      <= '0;
          dir_left <= 1'b1;
          if (p_start_c) begin
            state   <= RUN;
            running <= 1'b1;
            led     <= seed_of(mode_next_c);
          end
        end
        RUN, PAUSE: begin
          if (p_mode_c) begin
            led      <= seed_of(mode_next_c);
            dir_left <= 1'b1;
            cnt      <= '0;
          end else if (p_speed_c) begin
            cnt <= '0;
          end else if (state == RUN) begin
            if (tick_c) begin
              {dir_left, led} <= step_c;
              cnt             <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          if (p_start_c) begin
            state   <= (state == RUN) ? PAUSE : RUN;
            running <= (state != RUN);
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule
